// File: rtl/mem_port_arbiter_pkg.sv
// Shared core types: address/data words, memory op encoding,
// and the unified memory port arbiter state/owner enums.
package CorePack;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;

    typedef enum logic [2:0] {
        MEM_NO = 3'd0,
        MEM_B  = 3'd1,
        MEM_UB = 3'd2,
        MEM_H  = 3'd3,
        MEM_UH = 3'd4,
        MEM_W  = 3'd5,
        MEM_UW = 3'd6,
        MEM_D  = 3'd7
    } mem_op_enum;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    function automatic addr_t line_addr(addr_t a);
        return {a[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Store byte-lane generator: byte mask, lane-shifted data and
// misalignment flag from the access size and low address bits.
module store_lane_gen
    import CorePack::*;
(
    input  mem_op_enum  op_i,
    input  logic [2:0]  off_i,
    input  data_t       wdata_i,
    output logic [7:0]  wmask_o,
    output data_t       wdata_o,
    output logic        misalign_o
);

    always_comb begin
        wmask_o    = 8'h00;
        misalign_o = 1'b0;
        unique case (op_i)
            MEM_B, MEM_UB: begin
                wmask_o = 8'h01 << off_i;
            end
            MEM_H, MEM_UH: begin
                wmask_o    = 8'h03 << off_i;
                misalign_o = off_i[0];
            end
            MEM_W, MEM_UW: begin
                wmask_o    = 8'h0F << off_i;
                misalign_o = |off_i[1:0];
            end
            MEM_D: begin
                wmask_o    = 8'hFF;
                misalign_o = |off_i;
            end
            default: begin
                wmask_o    = 8'h00;
                misalign_o = 1'b0;
            end
        endcase
    end

    assign wdata_o = wdata_i << {off_i, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between
// instruction fetch and load/store, with fetch anti-starvation.
module mem_port_arbiter
    import CorePack::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rstn,

    input  logic       if_req,
    input  addr_t      if_addr,
    output logic       if_gnt,
    output logic       if_rvalid,
    output data_t      if_rdata,

    input  logic       ls_req,
    input  logic       ls_wen,
    input  mem_op_enum ls_op,
    input  addr_t      ls_addr,
    input  data_t      ls_wdata,
    output logic       ls_gnt,
    output logic       ls_rvalid,
    output data_t      ls_rdata,
    output logic       ls_err,

    output logic       mem_req,
    output logic       mem_wen,
    output addr_t      mem_addr,
    output data_t      mem_wdata,
    output logic [7:0] mem_wmask,
    input  logic       mem_gnt,
    input  logic       mem_rvalid,
    input  data_t      mem_rdata
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic [2:0] cnt_q, cnt_d;
    addr_t      addr_q, addr_d;
    data_t      wdata_q, wdata_d;
    logic [7:0] wmask_q, wmask_d;
    logic       wen_q, wen_d;

    logic [7:0] lane_mask;
    data_t      lane_wdata;
    logic       lane_misalign;
    logic       ls_pick;
    logic       if_pick;
    logic [2:0] cnt_inc;

    store_lane_gen u_lane (
        .op_i       (ls_op),
        .off_i      (ls_addr[2:0]),
        .wdata_i    (ls_wdata),
        .wmask_o    (lane_mask),
        .wdata_o    (lane_wdata),
        .misalign_o (lane_misalign)
    );

    // Grants are gated by rstn so nothing leaks out while held in reset.
    assign ls_pick = rstn && ls_req
                   && ((32'(cnt_q) < STARVE_LIMIT) || !if_req);
    assign if_pick = rstn && if_req && !ls_pick;
    assign cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        wen_d     = wen_q;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        ls_err    = 1'b0;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (ls_pick) begin
                    ls_gnt  = 1'b1;
                    owner_d = OWN_LS;
                    addr_d  = line_addr(ls_addr);
                    wdata_d = lane_wdata;
                    wmask_d = ls_wen ? lane_mask : 8'h00;
                    wen_d   = ls_wen && (ls_op != MEM_NO);
                    cnt_d   = if_req ? cnt_inc : 3'd0;
                    state_d = lane_misalign ? ERR : ISSUE;
                end else if (if_pick) begin
                    if_gnt  = 1'b1;
                    owner_d = OWN_IF;
                    addr_d  = line_addr(if_addr);
                    wdata_d = '0;
                    wmask_d = 8'h00;
                    wen_d   = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = 3'd0;
                end
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (owner_q == OWN_LS) begin
                    ls_rvalid = mem_rvalid;
                    ls_rdata  = mem_rdata;
                end else begin
                    if_rvalid = mem_rvalid;
                    if_rdata  = mem_rdata;
                end
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                ls_rvalid = 1'b1;
                ls_err    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of
// load/store accesses plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
    import CorePack::*;

    logic       clk;
    logic       rstn;
    logic       if_req;
    addr_t      if_addr;
    logic       if_gnt;
    logic       if_rvalid;
    data_t      if_rdata;
    logic       ls_req;
    logic       ls_wen;
    mem_op_enum ls_op;
    addr_t      ls_addr;
    data_t      ls_wdata;
    logic       ls_gnt;
    logic       ls_rvalid;
    data_t      ls_rdata;
    logic       ls_err;
    logic       mem_req;
    logic       mem_wen;
    addr_t      mem_addr;
    data_t      mem_wdata;
    logic [7:0] mem_wmask;
    logic       mem_gnt;
    logic       mem_rvalid;
    data_t      mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_wen     (ls_wen),
        .ls_op      (ls_op),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wen;
        mem_op_enum op;
        addr_t      addr;
        data_t      wdata;
        logic       err;
        addr_t      maddr;
        logic [7:0] mask;
        data_t      mwdata;
        logic       mwen;
        data_t      rdata;
    } vec_t;

    typedef struct {
        logic       err;
        addr_t      maddr;
        logic [7:0] mask;
        data_t      mwdata;
        logic       mwen;
        data_t      rdata;
    } exp_t;

    vec_t vecs[11];
    exp_t sbq[$];
    int   ncmp;
    int   nerr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".if_gnt"},    64'(if_gnt),    64'h0);
        chk({tag, ".ls_gnt"},    64'(ls_gnt),    64'h0);
        chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'h0);
        chk({tag, ".ls_rvalid"}, 64'(ls_rvalid), 64'h0);
        chk({tag, ".ls_err"},    64'(ls_err),    64'h0);
        chk({tag, ".if_rdata"},  if_rdata,       64'h0);
        chk({tag, ".ls_rdata"},  ls_rdata,       64'h0);
        chk({tag, ".mem_req"},   64'(mem_req),   64'h0);
        chk({tag, ".mem_wen"},   64'(mem_wen),   64'h0);
        chk({tag, ".mem_addr"},  mem_addr,       64'h0);
        chk({tag, ".mem_wdata"}, mem_wdata,      64'h0);
        chk({tag, ".mem_wmask"}, 64'(mem_wmask), 64'h0);
    endtask

    // Waits (bounded) for the chosen grant; called after settling.
    task automatic wait_gnt(input bit want_ls, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (want_ls ? ls_gnt : if_gnt) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_ls(input vec_t v, input string nm);
        bit   ok;
        exp_t e;
        @(negedge clk);
        ls_req   = 1'b1;
        ls_wen   = v.wen;
        ls_op    = v.op;
        ls_addr  = v.addr;
        ls_wdata = v.wdata;
        #1;
        wait_gnt(1'b1, ok);
        chk({nm, ".gnt"}, 64'(ok), 64'h1);
        if (!ok) begin
            ls_req = 1'b0;
            return;
        end
        chk({nm, ".if_gnt"}, 64'(if_gnt), 64'h0);
        sbq.push_back('{v.err, v.maddr, v.mask, v.mwdata, v.mwen, v.rdata});
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        e = sbq.pop_front();
        if (e.err) begin
            chk({nm, ".err_rvalid"}, 64'(ls_rvalid), 64'h1);
            chk({nm, ".err_flag"},   64'(ls_err),    64'h1);
            chk({nm, ".err_noreq"},  64'(mem_req),   64'h0);
            @(negedge clk);
            #1;
            chk({nm, ".err_once"}, 64'(ls_rvalid), 64'h0);
        end else begin
            chk({nm, ".req"},   64'(mem_req),   64'h1);
            chk({nm, ".addr"},  mem_addr,       e.maddr);
            chk({nm, ".mask"},  64'(mem_wmask), 64'(e.mask));
            chk({nm, ".wdata"}, mem_wdata,      e.mwdata);
            chk({nm, ".wen"},   64'(mem_wen),   64'(e.mwen));
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = e.rdata;
            #1;
            chk({nm, ".rvalid"}, 64'(ls_rvalid), 64'h1);
            chk({nm, ".rdata"},  ls_rdata,       e.rdata);
            chk({nm, ".noerr"},  64'(ls_err),    64'h0);
            chk({nm, ".if_rv"},  64'(if_rvalid), 64'h0);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        bit exp_if;
        ncmp = 0;
        nerr = 0;

        vecs[0]  = '{1'b1, MEM_B,  64'h1003, 64'hAB, 1'b0, 64'h1000,
                     8'h08, 64'h00000000AB000000, 1'b1, 64'h0};
        vecs[1]  = '{1'b1, MEM_H,  64'h2002, 64'hBEEF, 1'b0, 64'h2000,
                     8'h0C, 64'h00000000BEEF0000, 1'b1, 64'h0};
        vecs[2]  = '{1'b1, MEM_W,  64'h3004, 64'hDEADBEEF, 1'b0, 64'h3000,
                     8'hF0, 64'hDEADBEEF00000000, 1'b1, 64'h0};
        vecs[3]  = '{1'b1, MEM_D,  64'h4000, 64'h0123456789ABCDEF, 1'b0,
                     64'h4000, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 64'h0};
        vecs[4]  = '{1'b0, MEM_W,  64'h5004, 64'h0, 1'b0, 64'h5000,
                     8'h00, 64'h0, 1'b0, 64'hCAFEF00D12345678};
        vecs[5]  = '{1'b1, MEM_W,  64'h2006, 64'h55, 1'b1, 64'h0,
                     8'h00, 64'h0, 1'b0, 64'h0};
        vecs[6]  = '{1'b0, MEM_H,  64'h1001, 64'h0, 1'b1, 64'h0,
                     8'h00, 64'h0, 1'b0, 64'h0};
        vecs[7]  = '{1'b0, MEM_D,  64'h1004, 64'h0, 1'b1, 64'h0,
                     8'h00, 64'h0, 1'b0, 64'h0};
        vecs[8]  = '{1'b1, MEM_NO, 64'h6005, 64'h11, 1'b0, 64'h6000,
                     8'h00, 64'h0000110000000000, 1'b0, 64'hA5A5};
        vecs[9]  = '{1'b0, MEM_UB, 64'h7007, 64'h0, 1'b0, 64'h7000,
                     8'h00, 64'h0, 1'b0, 64'h8877665544332211};
        vecs[10] = '{1'b1, MEM_UH, 64'h8006, 64'h1234, 1'b0, 64'h8000,
                     8'hC0, 64'h1234000000000000, 1'b1, 64'h0};

        rstn       = 1'b0;
        if_req     = 1'b1;
        if_addr    = 64'h100;
        ls_req     = 1'b1;
        ls_wen     = 1'b1;
        ls_op      = MEM_D;
        ls_addr    = 64'h200;
        ls_wdata   = 64'hFFFF;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD;
        #12;
        chk_zero("reset");
        @(negedge clk);
        if_req     = 1'b0;
        ls_req     = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_ls(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests: load/store first, fetch right after.
        @(negedge clk);
        if_req   = 1'b1;
        if_addr  = 64'h3000;
        ls_req   = 1'b1;
        ls_wen   = 1'b1;
        ls_op    = MEM_B;
        ls_addr  = 64'h1003;
        ls_wdata = 64'hAB;
        #1;
        chk("both.ls_gnt", 64'(ls_gnt), 64'h1);
        chk("both.if_gnt", 64'(if_gnt), 64'h0);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        chk("both.mask", 64'(mem_wmask), 64'h08);
        chk("both.addr", mem_addr, 64'h1000);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0;
        #1;
        chk("both.ls_rvalid", 64'(ls_rvalid), 64'h1);
        chk("both.no_if_gnt", 64'(if_gnt), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("both.if_gnt_after", 64'(if_gnt), 64'h1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("both.if_addr", mem_addr, 64'h3000);
        chk("both.if_wen", 64'(mem_wen), 64'h0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BADC0DE0BADC0DE;
        #1;
        chk("both.if_rvalid", 64'(if_rvalid), 64'h1);
        chk("both.if_rdata", if_rdata, 64'h0BADC0DE0BADC0DE);
        chk("both.ls_quiet", 64'(ls_rvalid), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Starvation: expect L L L L I L L L L I.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 64'h9000;
        ls_req  = 1'b1;
        ls_wen  = 1'b0;
        ls_op   = MEM_D;
        ls_addr = 64'hA000;
        #1;
        for (int g = 0; g < 10; g++) begin
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (if_gnt || ls_gnt) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                #1;
            end
            chk($sformatf("starve.gnt%0d", g), 64'(ok), 64'h1);
            exp_if = (g == 4) || (g == 9);
            chk($sformatf("starve.order%0d", g), 64'(if_gnt), 64'(exp_if));
            chk($sformatf("starve.excl%0d", g),
                64'(if_gnt && ls_gnt), 64'h0);
            @(negedge clk);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 64'(g);
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (g == 9) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            #1;
        end

        // Memory stalls on a fetch.
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 64'h9ABC;
        #1;
        chk("stall.if_gnt", 64'(if_gnt), 64'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if_req  = 1'b0;
            mem_gnt = (k == 3);
            #1;
            chk($sformatf("stall.req%0d", k), 64'(mem_req), 64'h1);
            chk($sformatf("stall.addr%0d", k), mem_addr, 64'h9AB8);
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("stall.req_drop", 64'(mem_req), 64'h0);
        chk("stall.early_rv", 64'(if_rvalid), 64'h0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1122334455667788;
        #1;
        chk("stall.if_rvalid", 64'(if_rvalid), 64'h1);
        chk("stall.if_rdata", if_rdata, 64'h1122334455667788);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Reset while waiting for a load response.
        @(negedge clk);
        ls_req  = 1'b1;
        ls_wen  = 1'b0;
        ls_op   = MEM_D;
        ls_addr = 64'h500;
        #1;
        chk("rst.gnt", 64'(ls_gnt), 64'h1);
        @(negedge clk);
        ls_req  = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFEEDFACEFEEDFACE;
        if_req     = 1'b1;
        ls_req     = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        chk_zero("rst_wait");
        @(negedge clk);
        rstn       = 1'b1;
        mem_rvalid = 1'b0;
        if_req     = 1'b0;
        ls_addr    = 64'h508;
        #1;
        chk("rst.regrant", 64'(ls_gnt), 64'h1);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        chk("rst.req", 64'(mem_req), 64'h1);
        chk("rst.addr", mem_addr, 64'h508);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h77;
        #1;
        chk("rst.rvalid", 64'(ls_rvalid), 64'h1);
        chk("rst.rdata", ls_rdata, 64'h77);
        @(negedge clk);
        mem_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the core's single unified memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write). It is a one-outstanding-transaction arbiter: data-side priority with an anti-starvation counter for fetch. It generates store byte masks and lane-shifted store data from `mem_op`. Load data is returned unmodified as a 64-bit line; extraction and sign-extension happen downstream in the existing load-data truncation logic.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive data-side wins while fetch is pending before fetch is forced to win once.

Ports:
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` in 64: fetch address (`addr_t`).
- `if_gnt` out 1: one-cycle pulse, fetch request accepted.
- `if_rvalid` out 1: fetch response valid.
- `if_rdata` out 64: fetch response data.
- `ls_req` in 1: load/store request; held with all `ls_*` fields until `ls_gnt`.
- `ls_wen` in 1: 1 means store.
- `ls_op` in `mem_op_enum`: access size and signedness.
- `ls_addr` in 64: byte address.
- `ls_wdata` in 64: store data, right-aligned (byte 0 = LSB).
- `ls_gnt` out 1: one-cycle pulse, request accepted.
- `ls_rvalid` out 1: response valid (load data or store completion).
- `ls_rdata` out 64: raw memory line.
- `ls_err` out 1: misaligned access, valid with `ls_rvalid`.
- `mem_req` out 1: memory request.
- `mem_wen` out 1: memory write enable.
- `mem_addr` out 64: memory address, `ls_addr`/`if_addr` with bits [2:0] cleared.
- `mem_wdata` out 64: lane-shifted store data.
- `mem_wmask` out 8: byte enable mask.
- `mem_gnt` in 1: memory accepted the request this cycle.
- `mem_rvalid` in 1: memory response or write acknowledgement.
- `mem_rdata` in 64: memory read line.

## Operation
The FSM has four states: `IDLE`, `ISSUE`, `WAIT`, `ERR`.

In `IDLE`, the arbiter picks a winner from the requests sampled this cycle:
- If `ls_req` is asserted and `starve_cnt` < `STARVE_LIMIT`, or `if_req` is low, the load/store side wins. Otherwise fetch wins.
- The winner's fields are latched into request registers, the winner's `*_gnt` pulses this cycle, and the owner (IF or LS) is recorded.
- A misaligned load/store goes to `ERR`. Every other winning request goes to `ISSUE`.

`ISSUE`: `mem_req`=1 with the latched fields. Hold until `mem_gnt`, then go to `WAIT`.

`WAIT`:
- `if_rvalid`/`ls_rvalid` = `mem_rvalid` gated by owner, and the owner's `*_rdata` = `mem_rdata`. This is a combinational pass-through.
- On `mem_rvalid`, return to `IDLE`.

`ERR`: `ls_rvalid`=1 and `ls_err`=1 for one cycle, no memory access, then return to `IDLE`.

`starve_cnt` (3 bits, saturating):
- Increments when load/store wins in `IDLE` while `if_req`=1.
- Clears when fetch wins, or when `if_req`=0 in `IDLE`.

Store mask and data, with `off` = `ls_addr[2:0]`:
- B/UB: mask `8'h01<<off`.
- H/UH: mask `8'h03<<off`.
- W/UW: mask `8'h0F<<off`.
- D: mask `8'hFF`.
- `mem_wdata` = `ls_wdata << (off*8)`.
- Loads and fetches: `mem_wmask`=`8'h00`, `mem_wen`=0.
- `MEM_NO` with `ls_req` is treated as a zero-mask read.

Misaligned access:
- H is misaligned if `off[0]`≠0.
- W is misaligned if `off[1:0]`≠0.
- D is misaligned if `off`≠0.
- Fetch is never checked.

## Timing
- Reset (asynchronous, `rstn`=0): state `IDLE`, `starve_cnt`=0, and all outputs 0 (`mem_req`, `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wmask`, both `*_gnt`, both `*_rvalid`, `ls_err`, both `*_rdata`). A reset mid-transaction drops it silently; the memory shares `rstn`.
- Minimum latency: request sampled in cycle 0 (`gnt` pulse), `mem_req` in cycle 1, `mem_gnt` in cycle 1, `mem_rvalid` in cycle 2 at earliest, so the requester sees `rvalid` in cycle 2.
- The misaligned path returns `ls_rvalid`+`ls_err` in cycle 1.
- Exactly one transaction is in flight. Requests arriving outside `IDLE` wait, and the requester must hold `req`.
- `*_gnt` is asserted only in `IDLE`. `if_gnt` and `ls_gnt` are never high in the same cycle.
- `mem_rvalid` outside `WAIT` is ignored.
- `mem_rvalid` in the same cycle as `mem_gnt` (while in `ISSUE`) is a protocol violation and is not supported.

## Structure
- Add `arb_state_e` (`IDLE`/`ISSUE`/`WAIT`/`ERR`) and `arb_owner_e` (`OWN_IF`/`OWN_LS`) to `CorePack`. `mem_op_enum`, `addr_t` and `data_t` are reused from there.
- One sub-module: `store_lane_gen`, combinational, computing `mem_wmask`, `mem_wdata` and the misalign flag from (`ls_op`, `ls_addr[2:0]`, `ls_wdata`).

## Test plan
- Store byte:
  - Stimulus: `ls_req`, `ls_wen`=1, `MEM_B`, addr `0x1003`, wdata `0xAB`.
  - Required: `mem_addr` `0x1000`, `mem_wmask` `8'h08`, `mem_wdata` `0x00000000AB000000`; `ls_rvalid` on `mem_rvalid`.
- Simultaneous `if_req` and `ls_req` in `IDLE`:
  - Required: `ls_gnt` first. `if_gnt` in the first `IDLE` cycle after the LS response.
- Starvation:
  - Stimulus: `if_req` and `ls_req` held continuously, `STARVE_LIMIT`=4.
  - Required: grant order LS, LS, LS, LS, IF, LS…; `starve_cnt` returns to 0 after the IF grant.
- Misaligned `MEM_W` at addr `0x2006`:
  - Required: no `mem_req`. `ls_rvalid`=1 and `ls_err`=1 exactly one cycle after `ls_gnt`.
- Memory stalls:
  - Stimulus: `mem_gnt` withheld 3 cycles, then `mem_rvalid` 2 cycles later with rdata `0x1122334455667788` on a fetch.
  - Required: `mem_req` held steady for 4 cycles; `if_rdata` `0x1122334455667788` with `if_rvalid`.
- `rstn` pulled low during `WAIT`:
  - Required: all outputs 0 immediately.
  - After release, a new `ls_req` is granted in the first cycle.
